// File: rtl/pc_call_stack_unit.sv
// rtl/pc_call_stack_unit.sv - program counter with circular return-address stack
// and a single interrupt save slot.
module pc_call_stack_unit #(
    parameter int            PC_W    = 12,
    parameter int            DISP_W  = 8,
    parameter int            DEPTH   = 8,
    parameter logic [PC_W-1:0] RST_VEC = 'h000,
    parameter logic [PC_W-1:0] INT_VEC = 'h001
) (
    input  logic                         clkg,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   op,
    input  logic [PC_W-1:0]              target,
    input  logic [DISP_W-1:0]            disp,
    input  logic                         err_clr,
    output logic [PC_W-1:0]              pc_o,
    output logic [$clog2(DEPTH+1)-1:0]   sp_o,
    output logic                         stk_empty,
    output logic                         stk_full,
    output logic                         int_act,
    output logic                         ovf_err,
    output logic                         unf_err
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(DEPTH);

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_INT  = 3'd6;
    localparam logic [2:0] OP_RETI = 3'd7;

    logic [PC_W-1:0]  stack [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] wptr_next;
    logic [PTR_W-1:0] wptr_prev;
    logic [PC_W-1:0]  int_save;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_br;
    logic [PC_W-1:0]  disp_ext;
    logic [PC_W-1:0]  ret_addr;
    logic             is_full;
    logic             is_empty;

    // Pointer wraps explicitly so non-power-of-two depths stay circular.
    always_comb begin
        wptr_next = (wptr == PTR_LAST) ? '0 : wptr + PTR_W'(1);
        wptr_prev = (wptr == '0) ? PTR_LAST : wptr - PTR_W'(1);
        disp_ext  = {{(PC_W - DISP_W){disp[DISP_W-1]}}, disp};
        pc_inc    = pc_o + PC_W'(1);
        pc_br     = pc_inc + disp_ext;
        ret_addr  = stack[wptr_prev];
        is_full   = (sp_o == SP_FULL);
        is_empty  = (sp_o == '0);
    end

    assign stk_full  = is_full;
    assign stk_empty = is_empty;

    // Stack storage is not reset; only sp decides which entries are meaningful.
    always_ff @(posedge clkg) begin
        if (en && op == OP_CALL) begin
            stack[wptr] <= pc_inc;
        end
    end

    always_ff @(posedge clkg or posedge rst) begin
        if (rst) begin
            pc_o     <= RST_VEC;
            sp_o     <= '0;
            wptr     <= '0;
            int_act  <= 1'b0;
            int_save <= '0;
            ovf_err  <= 1'b0;
            unf_err  <= 1'b0;
        end else if (en) begin
            // Clear first so an error raised in the same cycle overrides it.
            if (err_clr) begin
                ovf_err <= 1'b0;
                unf_err <= 1'b0;
            end
            case (op)
                OP_HOLD: ;
                OP_INC:  pc_o <= pc_inc;
                OP_JMP:  pc_o <= target;
                OP_BR:   pc_o <= pc_br;
                OP_CALL: begin
                    pc_o <= target;
                    wptr <= wptr_next;
                    if (is_full) begin
                        ovf_err <= 1'b1;
                    end else begin
                        sp_o <= sp_o + SP_W'(1);
                    end
                end
                OP_RET: begin
                    if (is_empty) begin
                        pc_o    <= pc_inc;
                        unf_err <= 1'b1;
                    end else begin
                        pc_o <= ret_addr;
                        wptr <= wptr_prev;
                        sp_o <= sp_o - SP_W'(1);
                    end
                end
                OP_INT: begin
                    if (!int_act) begin
                        int_save <= pc_o;
                        pc_o     <= INT_VEC;
                        int_act  <= 1'b1;
                    end
                end
                OP_RETI: begin
                    if (int_act) begin
                        pc_o    <= int_save;
                        int_act <= 1'b0;
                    end else begin
                        pc_o <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_call_stack_unit.sv
// tb/tb_pc_call_stack_unit.sv - scoreboard bench for pc_call_stack_unit.
module tb_pc_call_stack_unit;

    localparam int DEPTH = 8;

    logic        clkg = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic [11:0] target;
    logic [7:0]  disp;
    logic        err_clr;
    logic [11:0] pc_o;
    logic [3:0]  sp_o;
    logic        stk_empty, stk_full, int_act, ovf_err, unf_err;

    pc_call_stack_unit #(.PC_W(12), .DISP_W(8), .DEPTH(DEPTH),
                         .RST_VEC(12'h000), .INT_VEC(12'h001)) dut (
        .clkg(clkg), .rst(rst), .en(en), .op(op), .target(target),
        .disp(disp), .err_clr(err_clr), .pc_o(pc_o), .sp_o(sp_o),
        .stk_empty(stk_empty), .stk_full(stk_full), .int_act(int_act),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clkg = ~clkg;

    typedef struct {
        string       tag;
        logic [11:0] pc;
        int          sp;
        logic        ia;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    logic [11:0] m_pc;
    logic [11:0] m_stk[$];
    logic        m_int;
    logic [11:0] m_save;
    logic        m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 12'h000;
        m_stk.delete();
        m_int = 1'b0;
        m_save = 12'h000;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic en_i, input logic [2:0] op_i,
                              input logic [11:0] tgt_i, input logic [7:0] disp_i,
                              input logic clr_i);
        if (!en_i) return;
        if (clr_i) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        case (op_i)
            3'd1: m_pc = m_pc + 12'd1;
            3'd2: m_pc = tgt_i;
            3'd3: m_pc = 12'(int'(m_pc) + 1 + int'($signed(disp_i)));
            3'd4: begin
                if (m_stk.size() == DEPTH) begin
                    void'(m_stk.pop_front());
                    m_ovf = 1'b1;
                end
                m_stk.push_back(m_pc + 12'd1);
                m_pc = tgt_i;
            end
            3'd5: begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin
                    m_pc = m_pc + 12'd1;
                    m_unf = 1'b1;
                end
            end
            3'd6: if (!m_int) begin
                m_save = m_pc;
                m_pc = 12'h001;
                m_int = 1'b1;
            end
            3'd7: begin
                if (m_int) begin
                    m_pc = m_save;
                    m_int = 1'b0;
                end else m_pc = m_pc + 12'd1;
            end
            default: ;
        endcase
    endtask

    task automatic check_state(input exp_t e);
        chk({e.tag, "_pc"},  32'(pc_o),      32'(e.pc));
        chk({e.tag, "_sp"},  32'(sp_o),      32'(e.sp));
        chk({e.tag, "_emp"}, 32'(stk_empty), 32'(e.sp == 0));
        chk({e.tag, "_ful"}, 32'(stk_full),  32'(e.sp == DEPTH));
        chk({e.tag, "_int"}, 32'(int_act),   32'(e.ia));
        chk({e.tag, "_ovf"}, 32'(ovf_err),   32'(e.ovf));
        chk({e.tag, "_unf"}, 32'(unf_err),   32'(e.unf));
    endtask

    task automatic step(input string tag, input logic en_i, input logic [2:0] op_i,
                        input logic [11:0] tgt_i, input logic [7:0] disp_i,
                        input logic clr_i);
        exp_t e;
        @(negedge clkg);
        en = en_i;
        op = op_i;
        target = tgt_i;
        disp = disp_i;
        err_clr = clr_i;
        model_step(en_i, op_i, tgt_i, disp_i, clr_i);
        e.tag = tag;
        e.pc = m_pc;
        e.sp = m_stk.size();
        e.ia = m_int;
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb.push_back(e);
        @(posedge clkg);
        #1;
        if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else check_state(sb.pop_front());
        en = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic apply_reset();
        exp_t e;
        @(negedge clkg);
        rst = 1'b1;
        en = 1'b0;
        #1;
        model_reset();
        e = '{tag: "rst", pc: 12'h000, sp: 0, ia: 1'b0, ovf: 1'b0, unf: 1'b0};
        check_state(e);
        @(negedge clkg);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        op = 3'd0;
        target = '0;
        disp = '0;
        err_clr = 1'b0;
        model_reset();

        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            step($sformatf("inc%0d", i), 1'b1, 3'd1, 12'h0, 8'h0, 1'b0);
            chk($sformatf("t1_pc%0d", i), 32'(pc_o), 32'(i));
        end

        step("jmp10", 1'b1, 3'd2, 12'h010, 8'h0, 1'b0);
        step("br_neg", 1'b1, 3'd3, 12'h0, 8'hFE, 1'b0);
        chk("t2_br", 32'(pc_o), 32'h00F);
        step("br_pos", 1'b1, 3'd3, 12'h0, 8'h7F, 1'b0);
        step("jmpfff", 1'b1, 3'd2, 12'hFFF, 8'h0, 1'b0);
        step("inc_wrap", 1'b1, 3'd1, 12'h0, 8'h0, 1'b0);
        chk("t2_wrap", 32'(pc_o), 32'h000);
        step("jmp123", 1'b1, 3'd2, 12'h123, 8'h0, 1'b0);

        step("jmp100", 1'b1, 3'd2, 12'h100, 8'h0, 1'b0);
        step("call200", 1'b1, 3'd4, 12'h200, 8'h0, 1'b0);
        step("call300", 1'b1, 3'd4, 12'h300, 8'h0, 1'b0);
        step("ret1", 1'b1, 3'd5, 12'h0, 8'h0, 1'b0);
        chk("t3_ret1", 32'(pc_o), 32'h201);
        step("ret2", 1'b1, 3'd5, 12'h0, 8'h0, 1'b0);
        chk("t3_ret2", 32'(pc_o), 32'h101);

        apply_reset();
        for (int k = 1; k <= 9; k++)
            step($sformatf("call_k%0d", k), 1'b1, 3'd4, 12'(16 * k), 8'h0, 1'b0);
        chk("t4_full", 32'(stk_full), 32'd1);
        chk("t4_ovf", 32'(ovf_err), 32'd1);
        for (int k = 1; k <= 8; k++)
            step($sformatf("ret_k%0d", k), 1'b1, 3'd5, 12'h0, 8'h0, 1'b0);
        chk("t4_last_ret", 32'(pc_o), 32'h011);
        step("ret_unf", 1'b1, 3'd5, 12'h0, 8'h0, 1'b0);
        chk("t4_unf", 32'(unf_err), 32'd1);
        step("clr", 1'b1, 3'd0, 12'h0, 8'h0, 1'b1);
        step("unf_again", 1'b1, 3'd5, 12'h0, 8'h0, 1'b0);
        step("clr_vs_err", 1'b1, 3'd5, 12'h0, 8'h0, 1'b1);
        step("clr_held", 1'b0, 3'd0, 12'h0, 8'h0, 1'b1);
        step("clr2", 1'b1, 3'd1, 12'h0, 8'h0, 1'b1);

        step("jmp55", 1'b1, 3'd2, 12'h055, 8'h0, 1'b0);
        step("int1", 1'b1, 3'd6, 12'h0, 8'h0, 1'b0);
        chk("t5_int", 32'(pc_o), 32'h001);
        step("int2", 1'b1, 3'd6, 12'h0, 8'h0, 1'b0);
        step("reti", 1'b1, 3'd7, 12'h0, 8'h0, 1'b0);
        chk("t5_reti", 32'(pc_o), 32'h055);
        step("reti_inc", 1'b1, 3'd7, 12'h0, 8'h0, 1'b0);

        step("call_a", 1'b1, 3'd4, 12'h3A0, 8'h0, 1'b0);
        step("en0_call", 1'b0, 3'd4, 12'h777, 8'h0, 1'b0);
        chk("t6_en0", 32'(pc_o), 32'h3A0);
        @(posedge clkg);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_pc", 32'(pc_o), 32'h000);
        chk("t6_async_sp", 32'(sp_o), 32'd0);
        chk("t6_async_emp", 32'(stk_empty), 32'd1);
        model_reset();
        @(negedge clkg);
        rst = 1'b0;
        step("post_rst", 1'b1, 3'd1, 12'h0, 8'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
